// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM demultiplexer.
// The demultiplexer drives the slot address to a 4:1 inverting mux and rebuilds the parallel word.
package tdm_pkg;
    typedef enum logic {IDLE, RUN} state_t;

    localparam int N_SLOTS         = 4;
    localparam int SLOT_W          = 2;
    localparam int SLOT_CYCLES_MIN = 1;
    localparam int SLOT_CYCLES_MAX = 256;

    function automatic bit slot_cycles_ok(input int n);
        return (n >= SLOT_CYCLES_MIN) && (n <= SLOT_CYCLES_MAX);
    endfunction
endpackage

// File: rtl/slot_timer.sv
// Cycle-within-slot counter and slot index. The strobe marks the last cycle of a slot.
module slot_timer
    import tdm_pkg::*;
#(
    parameter int SLOT_CYCLES = 4,
    localparam int CYC_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [CYC_W-1:0]  cyc,
    output logic              last,
    output logic [SLOT_W-1:0] slot
);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(SLOT_CYCLES - 1);

    assign last = (cyc == LAST_CYC);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cyc  <= '0;
            slot <= '0;
        end else if (advance) begin
            if (last) begin
                cyc  <= '0;
                slot <= slot + 1'b1;
            end else begin
                cyc <= cyc + 1'b1;
            end
        end
    end
endmodule

// File: rtl/tdm_demux.sv
// Receive end of the 4:1 inverting mux link: addresses slots, samples notY, commits 4-bit frames.
// The slot register drives A1:A0 directly, so the address is registered with no extra stage.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int SLOT_CYCLES = 4,
    parameter int CNT_W       = 8,
    localparam int CYC_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             notY,
    output logic             A0,
    output logic             A1,
    output logic [3:0]       Q,
    output logic             FRAME_VLD,
    output logic [CNT_W-1:0] FRAME_CNT,
    output logic             BUSY
);
    if (!slot_cycles_ok(SLOT_CYCLES)) begin : g_bad_slot_cycles
        $error("tdm_demux: SLOT_CYCLES out of range");
    end

    state_t            state;
    logic              adv;
    logic              last;
    logic              commit;
    logic [SLOT_W-1:0] slot;
    logic [CYC_W-1:0]  cyc;
    logic [2:0]        shadow;
    logic              data;

    assign data   = ~notY;
    // Dropping EN in RUN (or sitting in IDLE) holds the timer at slot 0, cycle 0.
    assign adv    = (state == RUN) && EN;
    assign commit = adv && last && (slot == SLOT_W'(N_SLOTS - 1));
    assign {A1, A0} = slot;

    slot_timer #(.SLOT_CYCLES(SLOT_CYCLES)) u_timer (
        .clk     (CLK),
        .rst     (RST),
        .clear   (!adv),
        .advance (adv),
        .cyc     (cyc),
        .last    (last),
        .slot    (slot)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            BUSY      <= 1'b0;
            shadow    <= '0;
            Q         <= '0;
            FRAME_VLD <= 1'b0;
            FRAME_CNT <= '0;
        end else begin
            FRAME_VLD <= commit;
            case (state)
                IDLE: begin
                    if (EN) begin
                        state <= RUN;
                        BUSY  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!EN) begin
                        state  <= IDLE;
                        BUSY   <= 1'b0;
                        shadow <= '0;
                    end else if (last) begin
                        if (commit) begin
                            Q         <= {data, shadow};
                            FRAME_CNT <= FRAME_CNT + 1'b1;
                        end else begin
                            for (int i = 0; i < 3; i++)
                                if (slot == SLOT_W'(i)) shadow[i] <= data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench: two demux instances (SLOT_CYCLES=2/CNT_W=8 and SLOT_CYCLES=1/CNT_W=2) each fed by an inverting 4:1 mux model.
module tb_tdm_demux;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst_a, en_a, noty_a, a0_a, a1_a, vld_a, busy_a;
    logic [3:0] d_a, q_a;
    logic [7:0] cnt_a;

    logic       rst_b, en_b, noty_b, a0_b, a1_b, vld_b, busy_b;
    logic [3:0] d_b, q_b;
    logic [1:0] cnt_b;

    // MUXX: inverting 4:1 multiplexer, combinational from the address
    assign noty_a = ~d_a[{a1_a, a0_a}];
    assign noty_b = ~d_b[{a1_b, a0_b}];

    tdm_demux #(.SLOT_CYCLES(2), .CNT_W(8)) dut_a (
        .CLK(clk), .RST(rst_a), .EN(en_a), .notY(noty_a), .A0(a0_a), .A1(a1_a),
        .Q(q_a), .FRAME_VLD(vld_a), .FRAME_CNT(cnt_a), .BUSY(busy_a)
    );

    tdm_demux #(.SLOT_CYCLES(1), .CNT_W(2)) dut_b (
        .CLK(clk), .RST(rst_b), .EN(en_b), .notY(noty_b), .A0(a0_b), .A1(a1_b),
        .Q(q_b), .FRAME_VLD(vld_b), .FRAME_CNT(cnt_b), .BUSY(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [1:0] a, input logic [3:0] q,
                         input logic vld, input logic [7:0] cnt, input logic busy);
        chk({tag, ".addr"}, {30'd0, a1_a, a0_a}, {30'd0, a});
        chk({tag, ".q"},    {28'd0, q_a},        {28'd0, q});
        chk({tag, ".vld"},  {31'd0, vld_a},      {31'd0, vld});
        chk({tag, ".cnt"},  {24'd0, cnt_a},      {24'd0, cnt});
        chk({tag, ".busy"}, {31'd0, busy_a},     {31'd0, busy});
    endtask

    logic [3:0] frames [3];

    initial begin
        frames[0] = 4'b0001;
        frames[1] = 4'b1111;
        frames[2] = 4'b0110;
        rst_a = 1'b1; en_a = 1'b0; d_a = 4'b0000;
        rst_b = 1'b1; en_b = 1'b0; d_b = 4'b1011;
        tick(); tick();
        chk_a("reset", 2'b00, 4'h0, 1'b0, 8'd0, 1'b0);
        rst_a = 1'b0;
        tick();
        chk_a("idle", 2'b00, 4'h0, 1'b0, 8'd0, 1'b0);

        // first frame, D=1010: address pairs per slot, commit 8 cycles after entering RUN
        d_a = 4'b1010; en_a = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("f1.addr%0d", k), {30'd0, a1_a, a0_a}, k / 2);
            chk($sformatf("f1.vld%0d", k), {31'd0, vld_a}, 32'd0);
            chk($sformatf("f1.busy%0d", k), {31'd0, busy_a}, 32'd1);
            tick();
        end
        chk_a("f1.done", 2'b00, 4'b1010, 1'b1, 8'd1, 1'b1);

        // three back-to-back frames, no gap
        for (int f = 0; f < 3; f++) begin
            d_a = frames[f];
            for (int k = 0; k < 8; k++) begin
                tick();
                if (k < 7) begin
                    chk($sformatf("b2b%0d.vld%0d", f, k), {31'd0, vld_a}, 32'd0);
                    chk($sformatf("b2b%0d.addr%0d", f, k), {30'd0, a1_a, a0_a}, (k + 1) / 2);
                end
            end
            chk_a($sformatf("b2b%0d.done", f), 2'b00, frames[f], 1'b1, 8'(2 + f), 1'b1);
        end

        // commit 1010 again, then abort during slot 2
        d_a = 4'b1010;
        repeat (8) tick();
        chk_a("pre_abort", 2'b00, 4'b1010, 1'b1, 8'd5, 1'b1);
        repeat (4) tick();
        chk({"abort.slot2"}, {30'd0, a1_a, a0_a}, 32'd2);
        en_a = 1'b0;
        tick();
        chk_a("abort", 2'b00, 4'b1010, 1'b0, 8'd5, 1'b0);
        d_a = 4'b0101;
        tick();
        chk_a("abort.hold", 2'b00, 4'b1010, 1'b0, 8'd5, 1'b0);
        en_a = 1'b1;
        tick();
        repeat (7) begin
            tick();
            chk("restart.vld", {31'd0, vld_a}, 32'd0);
        end
        tick();
        chk_a("restart", 2'b00, 4'b0101, 1'b1, 8'd6, 1'b1);

        // abort exactly on the slot-3 sampling cycle
        d_a = 4'b1100;
        repeat (7) tick();
        chk("s3abort.addr", {30'd0, a1_a, a0_a}, 32'd3);
        en_a = 1'b0;
        tick();
        chk_a("s3abort", 2'b00, 4'b0101, 1'b0, 8'd6, 1'b0);
        tick();
        chk_a("s3abort.hold", 2'b00, 4'b0101, 1'b0, 8'd6, 1'b0);

        // reset mid-frame with Q=1111, RST outranks EN
        d_a = 4'b1111; en_a = 1'b1;
        tick();
        repeat (8) tick();
        chk_a("prerst", 2'b00, 4'b1111, 1'b1, 8'd7, 1'b1);
        repeat (3) tick();
        rst_a = 1'b1;
        tick();
        chk_a("midrst", 2'b00, 4'h0, 1'b0, 8'd0, 1'b0);
        tick();
        chk_a("midrst.hold", 2'b00, 4'h0, 1'b0, 8'd0, 1'b0);
        rst_a = 1'b0;
        tick();
        chk_a("postrst", 2'b00, 4'h0, 1'b0, 8'd0, 1'b1);
        en_a = 1'b0;

        // SLOT_CYCLES=1, CNT_W=2: address every cycle, 5 frames, counter wraps
        rst_b = 1'b0; en_b = 1'b1;
        tick();
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("sc1.f%0d.addr%0d", f, k), {30'd0, a1_b, a0_b}, k);
                if (k > 0) chk($sformatf("sc1.f%0d.vld%0d", f, k), {31'd0, vld_b}, 32'd0);
                tick();
            end
            chk($sformatf("sc1.f%0d.vld", f), {31'd0, vld_b}, 32'd1);
            chk($sformatf("sc1.f%0d.cnt", f), {30'd0, cnt_b}, (f + 1) % 4);
            chk($sformatf("sc1.f%0d.q", f), {28'd0, q_b}, 32'hB);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
